// File: rtl/gcd_job_sequencer_pkg.sv
// Shared types for the GCD job sequencer: FSM states, default width, operand pair.
package gcd_pkg;

   localparam int GCD_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      WAIT,
      BYPASS,
      OUT,
      CLEAR
   } gcd_state_t;

   typedef struct packed {
      logic [GCD_WIDTH-1:0] a;
      logic [GCD_WIDTH-1:0] b;
   } gcd_pair_t;

endpackage

// File: rtl/gcd_job_sequencer_if.sv
// Job-side handshakes: operand pairs in, results out.
interface gcd_job_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_gcd;
   logic             res_err;

   modport master (
      output in_valid, in_a, in_b, res_ready,
      input  in_ready, res_valid, res_gcd, res_err
   );

   modport slave (
      input  in_valid, in_a, in_b, res_ready,
      output in_ready, res_valid, res_gcd, res_err
   );
endinterface

// File: rtl/gcd_job_sequencer_fifo.sv
// First-word-fall-through FIFO of operand pairs; head is valid whenever not empty.
module gcd_job_fifo
   import gcd_pkg::*;
#(
   parameter int  DEPTH  = 4,
   parameter type pair_t = gcd_pair_t
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  pair_t                  push_data,
   output pair_t                  head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);

   pair_t          mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           push_ok;
   logic           pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)
            count <= count + 1'b1;
         else if (pop_ok && !push_ok)
            count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/gcd_job_sequencer.sv
// Front end for the subtraction GCD core: queues pairs, feeds the core, returns results.
//
// state  | meaning
// IDLE   | waiting for a pair at the FIFO head
// LOAD_A | core_start high, A on core_data
// LOAD_B | B on core_data
// WAIT   | core running; timeout counter advancing
// BYPASS | a zero operand; result is A|B without the core
// OUT    | result presented until res_ready
// CLEAR  | one-cycle core_clr pulse, FIFO head popped
module gcd_job_sequencer
   import gcd_pkg::*;
#(
   parameter int WIDTH   = GCD_WIDTH,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 70000
) (
   input  logic             clk,
   input  logic             rst_n,
   gcd_job_if.slave         job,
   output logic [WIDTH-1:0] core_data,
   output logic             core_start,
   output logic             core_clr,
   input  logic             core_done,
   input  logic [WIDTH-1:0] core_result,
   output logic             busy
);
   localparam int CW = $clog2(TIMEOUT);
   localparam int NW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } pair_t;

   gcd_state_t       state;
   logic [CW-1:0]    cnt;
   pair_t            head;
   pair_t            push_data;
   logic [NW-1:0]    count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             clr_q;

   // in_ready looks only at the occupancy, never at a same-cycle pop.
   assign job.in_ready = rst_n && (count != NW'(DEPTH));
   assign push         = job.in_valid && !full;
   assign pop          = (state == CLEAR);
   assign push_data    = '{a: job.in_a, b: job.in_b};

   // The core is also held cleared for as long as reset is asserted.
   assign core_clr = clr_q || !rst_n;

   gcd_job_fifo #(
      .DEPTH  (DEPTH),
      .pair_t (pair_t)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   // Sequencer FSM with registered outputs; done takes priority over timeout.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         job.res_valid <= 1'b0;
         job.res_gcd   <= '0;
         job.res_err   <= 1'b0;
         core_data     <= '0;
         core_start    <= 1'b0;
         clr_q         <= 1'b0;
         busy          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  busy <= 1'b1;
                  if (head.a == '0 || head.b == '0) begin
                     state <= BYPASS;
                  end else begin
                     state      <= LOAD_A;
                     core_data  <= head.a;
                     core_start <= 1'b1;
                  end
               end
            end
            LOAD_A: begin
               state      <= LOAD_B;
               core_data  <= head.b;
               core_start <= 1'b0;
            end
            LOAD_B: begin
               state <= WAIT;
               cnt   <= '0;
            end
            WAIT: begin
               if (core_done) begin
                  state         <= OUT;
                  job.res_valid <= 1'b1;
                  job.res_gcd   <= core_result;
                  job.res_err   <= 1'b0;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  state         <= OUT;
                  job.res_valid <= 1'b1;
                  job.res_gcd   <= '0;
                  job.res_err   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BYPASS: begin
               state         <= OUT;
               job.res_valid <= 1'b1;
               job.res_gcd   <= head.a | head.b;
               job.res_err   <= 1'b0;
            end
            OUT: begin
               if (job.res_ready) begin
                  state         <= CLEAR;
                  job.res_valid <= 1'b0;
                  clr_q         <= 1'b1;
               end
            end
            CLEAR: begin
               state <= IDLE;
               clr_q <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
